// File: rtl/add32_seq_pkg.sv
// Shared constants for the serial adder: default width, FSM encodings and
// the debug view exported by the top level.
package add32_seq_pkg;

    localparam int CPU_XLEN    = 32;
    localparam int NIBBLES_DEF = CPU_XLEN / 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        state_t state;
        logic   sub;
        logic   carry;
    } dbg_t;

    // A single-nibble configuration still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add32_seq_full_add4.sv
// 4-bit ripple slice used once per cycle by add32_seq.
module full_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] sum,
    output logic       co
);

    assign {co, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/add32_seq.sv
// Nibble-serial adder/subtractor: one 4-bit slice processes the operands
// LSB nibble first; done pulses for one cycle after the last nibble.
//
// Handshake: an operation is accepted on a rising edge where start=1 and
// ready=1; ready drops the next cycle and returns high the cycle after the
// done pulse. start while ready=0 is dropped, never queued.
module add32_seq
    import add32_seq_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   ready,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   s,
    output logic                   cout,
    output logic                   ovf,
    output dbg_t                   dbg
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = idx_width(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic            r_sub;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_s;
    logic            r_ready;
    logic            r_done;
    logic            r_cout;
    logic            r_ovf;

    logic [IW+1:0]   w_base;
    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [3:0]      w_sum;
    logic            w_co;

    assign w_base  = {r_idx, 2'b00};
    assign w_a_nib = r_a[w_base +: 4];
    assign w_b_nib = r_b[w_base +: 4];

    full_add4 u_slice (
        .a   (w_a_nib),
        .b   (w_b_nib),
        .ci  (r_carry),
        .sum (w_sum),
        .co  (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && r_ready) begin
                        // Subtract is a + ~b + 1, so the inversion and forced carry happen here once.
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_sub   <= sub;
                        r_carry <= sub | cin;
                        r_idx   <= '0;
                        r_ready <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_s[w_base +: 4] <= w_sum;
                    r_carry          <= w_co;
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_cout  <= w_co;
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_sum[3] != r_a[W-1]);
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign s     = r_s;
    assign cout  = r_cout;
    assign ovf   = r_ovf;
    assign dbg   = '{state: r_state, sub: r_sub, carry: r_carry};

endmodule
